// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master / one-slave Wishbone B4 classic arbiter with a bus watchdog.
// Latency: the grant is registered, so the owner reaches the slave 1 cycle after its cyc is first seen;
//   after that the data and termination paths are purely combinational.
// Backpressure: the owner keeps the bus until it drops cyc; the non-owner waits with no termination.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   m0_*/m1_*                  master-side Wishbone classic (cyc/stb/we/adr/sel/dat in, dat/ack/err/rty out)
//   s_*                        shared slave-side Wishbone classic
//   gnt_o                      one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
//   timeout_o                  single-cycle pulse when the watchdog injects an error
module wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,

  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,

  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,

  output logic [1:0]              gnt_o,
  output logic                    timeout_o
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  // A zero TIMEOUT would give a zero-width counter; keep one dummy bit instead.
  localparam int WD_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [0:0] state;
  logic       owner;       // 0 = m0, 1 = m1; only meaningful while busy
  logic       last_owner;  // owner of the most recently finished cycle, drives the tie-break
  logic       busy;
  logic       own_cyc;
  logic       wd_fire;
  logic       term_ack;
  logic       term_err;
  logic       term_rty;

  assign busy    = (state == STATE_BUSY);
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;

  // ---------------------------------------------------------------------------
  // Ownership FSM. Every handoff passes through IDLE, so a waiting master sees
  // its grant two cycles after the previous owner drops cyc.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= STATE_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;  // makes m0 win the first tie after reset
    end else begin
      case (state)
        STATE_IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            state <= STATE_BUSY;
            owner <= (m0_cyc_i && m1_cyc_i) ? ~last_owner : m1_cyc_i;
          end
        end
        STATE_BUSY: begin
          if (!own_cyc) begin
            state      <= STATE_IDLE;
            last_owner <= owner;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign gnt_o = busy ? {owner, ~owner} : 2'b00;

  // ---------------------------------------------------------------------------
  // Master-to-slave mux: combinational from the owner, all zero while idle so
  // s_cyc_o falls in the same cycle the owner releases cyc.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (busy) begin
      if (owner) begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end else begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slave-to-master path. Read data is broadcast; terminations only ever reach
  // the current owner, and only while busy.
  // ---------------------------------------------------------------------------
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign term_ack = busy & s_ack_i;
  assign term_err = busy & (s_err_i | wd_fire);
  assign term_rty = busy & s_rty_i;

  assign m0_ack_o = term_ack & ~owner;
  assign m0_err_o = term_err & ~owner;
  assign m0_rty_o = term_rty & ~owner;
  assign m1_ack_o = term_ack &  owner;
  assign m1_err_o = term_err &  owner;
  assign m1_rty_o = term_rty &  owner;

  assign timeout_o = wd_fire;

  // ---------------------------------------------------------------------------
  // Bus watchdog. The counter measures consecutive unterminated strobe cycles;
  // reaching TIMEOUT injects one err to the owner, unless the slave happens to
  // terminate in that same cycle, in which case the slave wins.
  // ---------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT);

      logic [WD_WIDTH-1:0] wd_cnt;
      logic                own_stb;
      logic                slave_term;

      assign own_stb    = owner ? m1_stb_i : m0_stb_i;
      assign slave_term = s_ack_i | s_err_i | s_rty_i;
      assign wd_fire    = busy && own_stb && !slave_term && (wd_cnt == WD_LIMIT);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wd_cnt <= '0;
        end else if (!busy || !own_stb || slave_term || wd_fire) begin
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter (TIMEOUT = 4 main instance, TIMEOUT = 0 twin).
// Latency: inputs change 1 ns after a rising edge, outputs are sampled on the falling edge.
// Backpressure: the bench acts as both masters and the slave, so it controls every handshake.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;

  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;

  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;

  logic [1:0]  gnt_o;
  logic        timeout_o;

  // outputs of the TIMEOUT = 0 twin
  logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
  logic        z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o;
  logic        z_s_cyc_o, z_s_stb_o, z_s_we_o, z_timeout_o;
  logic [3:0]  z_s_sel_o;
  logic [1:0]  z_gnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_dat_q[$];
  logic [1:0]  exp_gnt_q[$];

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) u_dut_nowd (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(z_m0_dat_o),
    .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(z_m1_dat_o),
    .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o),
    .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o), .s_adr_o(z_s_adr_o),
    .s_sel_o(z_s_sel_o), .s_dat_o(z_s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(z_gnt_o), .timeout_o(z_timeout_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m0_adr_i = '0;   m0_sel_i = 4'hF; m0_dat_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m1_adr_i = '0;   m1_sel_i = 4'h3; m1_dat_i = '0;
    s_dat_i  = '0;   s_ack_i  = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic pop_dat(input logic [31:0] got, input string name);
    logic [31:0] exp;
    checks++;
    if (exp_dat_q.size() == 0) begin
      errors++;
      $display("FAIL %s: data 0x%08h seen but scoreboard empty", name, got);
    end else begin
      exp = exp_dat_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
    end
  endtask

  task automatic pop_gnt(input string name);
    logic [1:0] exp;
    checks++;
    if (exp_gnt_q.size() == 0) begin
      errors++;
      $display("FAIL %s: gnt %b seen but scoreboard empty", name, gnt_o);
    end else begin
      exp = exp_gnt_q.pop_front();
      if (gnt_o !== exp) begin
        errors++;
        $display("FAIL %s: gnt got %b expected %b", name, gnt_o, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    tick(); tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== '0) begin
      errors++; $display("FAIL reset_slave: cyc/stb/we=%b%b%b adr=%h sel=%h dat=%h expected all 0",
                         s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o);
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, timeout_o} !== 7'b0) begin
      errors++; $display("FAIL reset_terms: got %b expected 0000000",
                         {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, timeout_o});
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h2000_0000;
    s_dat_i  = 32'h1111_1111;
    exp_dat_q.push_back(32'hCAFE_0001);
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL read_latency: gnt %b s_cyc %b expected 00 0 on request cycle", gnt_o, s_cyc_o);
    end
    tick();  // stb reaches the slave in this cycle
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h2000_0000 || s_sel_o !== 4'hF) begin
      errors++; $display("FAIL read_grant: gnt %b cyc %b stb %b adr %h sel %h expected 01 1 1 20000000 f",
                         gnt_o, s_cyc_o, s_stb_o, s_adr_o, s_sel_o);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b expected 0", m0_ack_o); end
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
    @(negedge clk_i);
    checks++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL read_ack: m0_ack %b m1_ack %b expected 1 0", m0_ack_o, m1_ack_o);
    end
    pop_dat(m0_dat_o, "read_data");
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (s_cyc_o !== 1'b0 || gnt_o !== 2'b01) begin
      errors++; $display("FAIL read_release: s_cyc %b gnt %b expected 0 01", s_cyc_o, gnt_o);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b00) begin errors++; $display("FAIL read_idle: gnt %b expected 00", gnt_o); end
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int r = 0; r < 4; r++) begin
      tick();
      m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      exp_gnt_q.push_back(2'b01);
      exp_gnt_q.push_back(2'b10);
      tick();
      @(negedge clk_i);
      pop_gnt("rr_first");
      tick();
      m0_cyc_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_drop: s_cyc %b expected 0", s_cyc_o); end
      tick();
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 2'b00) begin errors++; $display("FAIL rr_gap: gnt %b expected 00", gnt_o); end
      tick();
      @(negedge clk_i);
      pop_gnt("rr_second");
      tick();
      m1_cyc_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] adr [3];
    logic [31:0] dat [3];
    adr[0] = 32'h2000_0100; adr[1] = 32'h2000_0104; adr[2] = 32'h2000_0108;
    dat[0] = 32'hA0A0_0000; dat[1] = 32'hB1B1_1111; dat[2] = 32'hC2C2_2222;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = adr[0];
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'hDEAD_0000;
    tick();
    for (int p = 0; p < 3; p++) begin
      m0_adr_i = adr[p];
      m0_we_i  = (p == 1);
      m0_dat_i = 32'h5A5A_0000 + p;
      exp_dat_q.push_back(dat[p]);
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 2'b01 || s_adr_o !== adr[p] || s_we_o !== (p == 1) || s_dat_o !== 32'h5A5A_0000 + p) begin
        errors++; $display("FAIL b2b_phase%0d: gnt %b adr %h we %b wdat %h expected 01 %h %b %h",
                           p, gnt_o, s_adr_o, s_we_o, s_dat_o, adr[p], (p == 1), 32'h5A5A_0000 + p);
      end
      tick();
      s_ack_i = 1'b1; s_dat_i = dat[p];
      @(negedge clk_i);
      checks++;
      if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || gnt_o !== 2'b01) begin
        errors++; $display("FAIL b2b_ack%0d: m0_ack %b m1_ack %b gnt %b expected 1 0 01", p, m0_ack_o, m1_ack_o, gnt_o);
      end
      pop_dat(m0_dat_o, "b2b_data");
      tick();
      s_ack_i = 1'b0;
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b10 || s_adr_o !== 32'hDEAD_0000) begin
      errors++; $display("FAIL b2b_handoff: gnt %b adr %h expected 10 dead0000", gnt_o, s_adr_o);
    end
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic exp_err, exp_to;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h4000_0000;
    tick();
    for (int i = 1; i <= 17; i++) begin
      s_ack_i = (i == 15); s_err_i = (i == 16); s_rty_i = (i == 17);
      exp_err = (i == 5) || (i == 10) || (i == 16);
      exp_to  = (i == 5) || (i == 10);
      @(negedge clk_i);
      checks++;
      if (m1_err_o !== exp_err || timeout_o !== exp_to) begin
        errors++; $display("FAIL wd_cycle%0d: m1_err %b timeout %b expected %b %b", i, m1_err_o, timeout_o, exp_err, exp_to);
      end
      checks++;
      if (m1_ack_o !== (i == 15) || m1_rty_o !== (i == 17) || {m0_ack_o, m0_err_o, m0_rty_o} !== 3'b000) begin
        errors++; $display("FAIL wd_terms%0d: m1_ack %b m1_rty %b m0_terms %b expected %b %b 000",
                           i, m1_ack_o, m1_rty_o, {m0_ack_o, m0_err_o, m0_rty_o}, (i == 15), (i == 17));
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    tick();
    m0_cyc_i = 1'b1;
    tick(); tick();
    m0_cyc_i = 1'b0;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b10) begin errors++; $display("FAIL rstmid_owner: gnt %b expected 10", gnt_o); end
    tick();
    rst_i = 1'b1; s_ack_i = 1'b1;
    tick();
    rst_i = 1'b0; m0_cyc_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || timeout_o !== 1'b0 ||
        {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) begin
      errors++; $display("FAIL rstmid_clear: gnt %b s_cyc %b s_stb %b to %b terms %b expected 00 0 0 0 000000",
                         gnt_o, s_cyc_o, s_stb_o, timeout_o,
                         {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o});
    end
    tick();
    s_ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b01) begin errors++; $display("FAIL rstmid_tie: gnt %b expected 01", gnt_o); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout_disabled();
    int wd_pulses = 0;
    int bad = 0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h4000_0004;
    tick();
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk_i);
      if (z_m0_err_o !== 1'b0 || z_timeout_o !== 1'b0 || z_m1_err_o !== 1'b0) bad++;
      if (m0_err_o === 1'b1 && timeout_o === 1'b1) wd_pulses++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL nowd_quiet: %0d cycles with err/timeout, expected 0", bad); end
    checks++;
    if (z_gnt_o !== 2'b01) begin errors++; $display("FAIL nowd_gnt: gnt %b expected 01", z_gnt_o); end
    checks++;
    if (wd_pulses != 1000) begin errors++; $display("FAIL wd4_pulses: got %0d expected 1000", wd_pulses); end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_timeout_disabled();
    checks++;
    if (exp_dat_q.size() != 0 || exp_gnt_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d data %0d grants still expected", exp_dat_q.size(), exp_gnt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
